// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM unified-memory port arbiter.
package mips_mem_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// Winner selection between fetch and data requests, with a saturating
// starvation counter that forces a fetch grant after STARVE_MAX losses.
module mem_arb_prio
  import mips_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  input  logic arb_en,
  output logic grant_if,
  output logic grant_dm
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;
  logic          starved;

  always_comb begin
    starved  = (starve_cnt == SW'(STARVE_MAX));
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (arb_en) begin
      if (if_req && (!dm_req || starved)) begin
        grant_if = 1'b1;
      end else if (dm_req) begin
        grant_dm = 1'b1;
      end
    end
  end

  // Only arbitration cycles move the counter; it is held while an access is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (if_req && !grant_if) begin
        if (!starved) begin
          starve_cnt <= starve_cnt + SW'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access:
// one access at a time, fixed-latency completion acked back to the owner.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem
);

  localparam int unsigned LW = $clog2(MEM_LAT + 1);

  arb_state_t    state, state_nx;
  owner_t        owner, owner_nx;
  logic [LW-1:0] lat_cnt, lat_cnt_nx;
  logic          arb_en;
  logic          grant_if;
  logic          grant_dm;

  assign arb_en = (state == IDLE) && !rst;

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .dm_req  (dm_req),
    .arb_en  (arb_en),
    .grant_if(grant_if),
    .grant_dm(grant_dm)
  );

  always_comb begin
    state_nx   = state;
    owner_nx   = owner;
    lat_cnt_nx = lat_cnt;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = if_addr;
    mem_wdata  = dm_wdata;
    if_ack     = 1'b0;
    dm_ack     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_if || grant_dm) begin
          mem_en     = 1'b1;
          mem_we     = grant_dm && dm_we;
          mem_addr   = grant_dm ? dm_addr : if_addr;
          owner_nx   = grant_dm ? OWN_DM : OWN_IF;
          lat_cnt_nx = LW'(MEM_LAT);
          state_nx   = WAIT;
        end
      end
      WAIT: begin
        lat_cnt_nx = lat_cnt - LW'(1);
        // Acks are gated by rst so an access interrupted by reset never completes.
        if (!rst && (lat_cnt == LW'(1))) begin
          if_ack   = (owner == OWN_IF);
          dm_ack   = (owner == OWN_DM);
          owner_nx = OWN_NONE;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= OWN_NONE;
      lat_cnt <= '0;
    end else begin
      state   <= state_nx;
      owner   <= owner_nx;
      lat_cnt <= lat_cnt_nx;
    end
  end

  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1/STARVE_MAX=2 and
// MEM_LAT=3/STARVE_MAX=4) checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i      [NI];
  logic        if_req_i   [NI];
  logic        dm_req_i   [NI];
  logic        dm_we_i    [NI];
  logic [31:0] if_addr_i  [NI];
  logic [31:0] dm_addr_i  [NI];
  logic [31:0] dm_wdata_i [NI];
  logic [31:0] mem_rdata_i[NI];

  logic        if_ack_a, dm_ack_a, mem_en_a, mem_we_a, stall_if_a, stall_mem_a;
  logic [31:0] if_rdata_a, dm_rdata_a, mem_addr_a, mem_wdata_a;
  logic        if_ack_b, dm_ack_b, mem_en_b, mem_we_b, stall_if_b, stall_mem_b;
  logic [31:0] if_rdata_b, dm_rdata_b, mem_addr_b, mem_wdata_b;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(2)) u_dut_a (
    .clk(clk), .rst(rst_i[0]),
    .if_req(if_req_i[0]), .if_addr(if_addr_i[0]), .if_rdata(if_rdata_a), .if_ack(if_ack_a),
    .dm_req(dm_req_i[0]), .dm_we(dm_we_i[0]), .dm_addr(dm_addr_i[0]), .dm_wdata(dm_wdata_i[0]),
    .dm_rdata(dm_rdata_a), .dm_ack(dm_ack_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_i[0]), .stall_if(stall_if_a), .stall_mem(stall_mem_a));

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut_b (
    .clk(clk), .rst(rst_i[1]),
    .if_req(if_req_i[1]), .if_addr(if_addr_i[1]), .if_rdata(if_rdata_b), .if_ack(if_ack_b),
    .dm_req(dm_req_i[1]), .dm_we(dm_we_i[1]), .dm_addr(dm_addr_i[1]), .dm_wdata(dm_wdata_i[1]),
    .dm_rdata(dm_rdata_b), .dm_ack(dm_ack_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_i[1]), .stall_if(stall_if_b), .stall_mem(stall_mem_b));

  int total = 0;
  int bad   = 0;

  // Transaction-level model: an access issued at cycle iss completes at iss+latency.
  int unsigned cyc = 0;
  bit          busy  [NI];
  int unsigned iss   [NI];
  int          own   [NI];   // 1 = fetch, 2 = data
  int          losses[NI];

  bit          e_ack_if[NI], e_ack_dm[NI];
  logic        o_en[NI], o_we[NI], o_ack_if[NI], o_ack_dm[NI], o_stall_if[NI], o_stall_mem[NI];
  logic [31:0] o_addr[NI], o_wdata[NI], o_rd_if[NI], o_rd_dm[NI];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int smax_of(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit due[NI], e_en[NI], e_we;
    int win[NI];
    #4;
    o_en[0] = mem_en_a;   o_we[0] = mem_we_a;   o_addr[0] = mem_addr_a; o_wdata[0] = mem_wdata_a;
    o_ack_if[0] = if_ack_a; o_ack_dm[0] = dm_ack_a; o_stall_if[0] = stall_if_a;
    o_stall_mem[0] = stall_mem_a; o_rd_if[0] = if_rdata_a; o_rd_dm[0] = dm_rdata_a;
    o_en[1] = mem_en_b;   o_we[1] = mem_we_b;   o_addr[1] = mem_addr_b; o_wdata[1] = mem_wdata_b;
    o_ack_if[1] = if_ack_b; o_ack_dm[1] = dm_ack_b; o_stall_if[1] = stall_if_b;
    o_stall_mem[1] = stall_mem_b; o_rd_if[1] = if_rdata_b; o_rd_dm[1] = dm_rdata_b;
    for (int k = 0; k < NI; k++) begin
      due[k] = !rst_i[k] && busy[k] && (cyc == iss[k] + lat_of(k));
      e_ack_if[k] = due[k] && (own[k] == 1);
      e_ack_dm[k] = due[k] && (own[k] == 2);
      e_en[k] = !rst_i[k] && !busy[k] && (if_req_i[k] || dm_req_i[k]);
      if (if_req_i[k] && dm_req_i[k]) win[k] = (losses[k] == smax_of(k)) ? 1 : 2;
      else                            win[k] = if_req_i[k] ? 1 : 2;
      e_we = e_en[k] && (win[k] == 2) && dm_we_i[k];
      chk($sformatf("mem_en%0d", k),    32'(o_en[k]),        32'(e_en[k]));
      chk($sformatf("mem_we%0d", k),    32'(o_we[k]),        32'(e_we));
      chk($sformatf("if_ack%0d", k),    32'(o_ack_if[k]),    32'(e_ack_if[k]));
      chk($sformatf("dm_ack%0d", k),    32'(o_ack_dm[k]),    32'(e_ack_dm[k]));
      chk($sformatf("stall_if%0d", k),  32'(o_stall_if[k]),  32'(if_req_i[k] && !e_ack_if[k]));
      chk($sformatf("stall_mem%0d", k), 32'(o_stall_mem[k]), 32'(dm_req_i[k] && !e_ack_dm[k]));
      chk($sformatf("if_rdata%0d", k),  o_rd_if[k], mem_rdata_i[k]);
      chk($sformatf("dm_rdata%0d", k),  o_rd_dm[k], mem_rdata_i[k]);
      if (e_en[k])
        chk($sformatf("mem_addr%0d", k), o_addr[k], (win[k] == 2) ? dm_addr_i[k] : if_addr_i[k]);
      if (e_we)
        chk($sformatf("mem_wdata%0d", k), o_wdata[k], dm_wdata_i[k]);
    end
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      if (rst_i[k]) begin
        busy[k] = 1'b0;
        losses[k] = 0;
      end else if (busy[k]) begin
        if (due[k]) busy[k] = 1'b0;
      end else if (e_en[k]) begin
        busy[k] = 1'b1;
        iss[k]  = cyc;
        own[k]  = win[k];
        if (if_req_i[k] && (win[k] == 2)) losses[k] = (losses[k] < smax_of(k)) ? losses[k] + 1 : losses[k];
        else                              losses[k] = 0;
      end else begin
        losses[k] = 0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic clear_in(input int k);
    rst_i[k] = 1'b0; if_req_i[k] = 1'b0; dm_req_i[k] = 1'b0; dm_we_i[k] = 1'b0;
  endtask

  initial begin
    int grants[$];
    int exp_g[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
    int en_cnt;

    for (int k = 0; k < NI; k++) begin
      rst_i[k] = 1'b1; if_req_i[k] = 1'b1; dm_req_i[k] = 1'b1; dm_we_i[k] = 1'b0;
      if_addr_i[k] = 32'h40; dm_addr_i[k] = 32'h80; dm_wdata_i[k] = '0; mem_rdata_i[k] = 32'h1234_5678;
      busy[k] = 1'b0; iss[k] = 0; own[k] = 0; losses[k] = 0;
    end
    #1;

    // Reset held with both requests pending
    for (int i = 0; i < 3; i++) step();
    chk("rst_stall_if", 32'(o_stall_if[1]), 32'd1);
    chk("rst_mem_en",   32'(o_en[1]),       32'd0);
    rst_i[0] = 1'b0; rst_i[1] = 1'b0;
    step();
    chk("rel_dm_first", o_addr[1], 32'h80);
    chk("rel_en",       32'(o_en[1]), 32'd1);
    clear_in(0); clear_in(1);
    for (int i = 0; i < 4; i++) step();

    // Fetch only, latency 1
    if_req_i[0] = 1'b1; if_addr_i[0] = 32'h40; mem_rdata_i[0] = 32'h2108_000A;
    step();
    chk("if_issue_en",   32'(o_en[0]), 32'd1);
    chk("if_issue_addr", o_addr[0], 32'h40);
    step();
    chk("if_ack_t1",   32'(o_ack_if[0]), 32'd1);
    chk("if_rdata_t1", o_rd_if[0], 32'h2108_000A);
    clear_in(0);
    step();

    // Data store, latency 3
    dm_req_i[1] = 1'b1; dm_we_i[1] = 1'b1; dm_addr_i[1] = 32'h100; dm_wdata_i[1] = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("st_en_t%0d", i),    32'(o_en[1]),        32'(i == 0));
      chk($sformatf("st_ack_t%0d", i),   32'(o_ack_dm[1]),    32'(i == 3));
      chk($sformatf("st_stall_t%0d", i), 32'(o_stall_mem[1]), 32'(i != 3));
      if (i == 0) chk("st_wdata", o_wdata[1], 32'hDEAD_BEEF);
    end
    clear_in(1);
    step();

    // Both held continuously: fetch wins after four losses
    if_req_i[1] = 1'b1; if_addr_i[1] = 32'h200;
    dm_req_i[1] = 1'b1; dm_addr_i[1] = 32'h300; dm_we_i[1] = 1'b0;
    for (int i = 0; i < 60 && grants.size() < 10; i++) begin
      step();
      if (o_en[1]) grants.push_back((o_addr[1] == 32'h300) ? 2 : 1);
    end
    chk("grant_count", 32'(grants.size()), 32'd10);
    for (int i = 0; i < 10 && i < grants.size(); i++)
      chk($sformatf("grant%0d", i), 32'(grants[i]), 32'(exp_g[i]));
    clear_in(1);
    for (int i = 0; i < 4; i++) step();

    // Reset pulse while an access is in flight
    dm_req_i[1] = 1'b1; dm_addr_i[1] = 32'h500;
    step();
    chk("rw_issue", 32'(o_en[1]), 32'd1);
    rst_i[1] = 1'b1; dm_req_i[1] = 1'b0;
    step();
    rst_i[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rw_noack%0d", i), 32'(o_ack_dm[1]), 32'd0);
    end
    dm_req_i[1] = 1'b1; dm_addr_i[1] = 32'h504;
    step();
    chk("rw_fresh_addr", o_addr[1], 32'h504);
    for (int i = 0; i < 3; i++) step();
    chk("rw_fresh_ack", 32'(o_ack_dm[1]), 32'd1);
    clear_in(1);
    step();

    // Fetch request withdrawn early: access still completes, no reissue
    if_req_i[1] = 1'b1; if_addr_i[1] = 32'h600;
    step();
    if_req_i[1] = 1'b0;
    en_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (o_en[1]) en_cnt++;
      if (i == 3) chk("drop_ack", 32'(o_ack_if[1]), 32'd1);
    end
    chk("drop_no_reissue", 32'(en_cnt), 32'd0);

    // Randomized traffic, mostly protocol-compliant requesters
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NI; k++) begin
        rst_i[k] = ($urandom_range(0, 59) == 0);
        mem_rdata_i[k] = $urandom;
        if (!if_req_i[k]) begin
          if ($urandom_range(0, 2) == 0) begin if_req_i[k] = 1'b1; if_addr_i[k] = $urandom; end
        end else if ($urandom_range(0, 40) == 0) if_req_i[k] = 1'b0;
        if (!dm_req_i[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            dm_req_i[k] = 1'b1; dm_we_i[k] = $urandom_range(0, 1) == 1;
            dm_addr_i[k] = $urandom; dm_wdata_i[k] = $urandom;
          end
        end else if ($urandom_range(0, 40) == 0) dm_req_i[k] = 1'b0;
      end
      step();
      for (int k = 0; k < NI; k++) begin
        if (e_ack_if[k] && $urandom_range(0, 1) == 0) if_req_i[k] = 1'b0;
        if (e_ack_dm[k] && $urandom_range(0, 1) == 0) dm_req_i[k] = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
